// File: rtl/turbo_pkg.sv
// Shared turbo-code constants: block geometry, FSM states, interleaver and RSC generators.
// The matching Decoder block imports this package as well.
package turbo_pkg;
  localparam int INPUT_SIZE  = 5;
  localparam int EXTEND_SIZE = INPUT_SIZE + 2;
  localparam int BLOCK_SIZE  = 3 * EXTEND_SIZE;

  localparam logic [2:0] G_FB = 3'o7;
  localparam logic [2:0] G_FF = 3'o5;

  // itl[k] = sys[ITL_PERM[k]], i.e. 3k mod 7
  localparam logic [2:0] ITL_PERM [EXTEND_SIZE] = '{3'd0, 3'd3, 3'd6, 3'd2, 3'd5, 3'd1, 3'd4};

  typedef enum logic [1:0] {S_IDLE, S_ENC1, S_ENC2, S_OUT} state_t;
endpackage

// File: rtl/rsc_encoder.sv
// Recursive systematic convolutional encoder (feedback G_FB, feedforward G_FF), one step per cycle.
// term replaces u with the feedback sum so the register drains to zero.
module rsc_encoder
  import turbo_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic term,
  input  logic u,
  output logic sys_o,
  output logic par_o
);
  logic s1, s2, fb, uin, a;

  always_comb begin
    fb    = (G_FB[1] & s1) ^ (G_FB[0] & s2);
    uin   = term ? fb : u;
    a     = (G_FB[2] & uin) ^ fb;
    sys_o = uin;
    par_o = (G_FF[2] & a) ^ (G_FF[1] & s1) ^ (G_FF[0] & s2);
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else if (en) begin
      s1 <= a;
      s2 <= s1;
    end
  end
endmodule

// File: rtl/turbo_encoder.sv
// Rate-1/3 bit-serial turbo encoder: natural-order RSC pass, then interleaved-order pass,
// codeword packed {sys, par1, par2} with bit (base+k) = trellis step k.
module turbo_encoder
  import turbo_pkg::*;
(
  input  logic                  clk_p_i,
  input  logic                  reset_p_i,
  input  logic [INPUT_SIZE-1:0] data_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  output logic [BLOCK_SIZE-1:0] data_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i
);
  localparam logic [2:0] LAST_STEP = 3'(EXTEND_SIZE - 1);

  state_t                 state;
  logic [2:0]             step;
  logic [INPUT_SIZE-1:0]  msg;
  logic [EXTEND_SIZE-1:0] sys, par1, par2;
  logic                   last, rsc_clr, rsc_en, rsc_term, rsc_u, sys_bit, par_bit;

  always_comb begin
    last     = (step == LAST_STEP);
    rsc_clr  = (state == S_IDLE) || (state == S_ENC1 && last);
    rsc_en   = (state == S_ENC1) || (state == S_ENC2);
    rsc_term = (state == S_ENC1) && (step >= 3'(INPUT_SIZE));
    // sys is complete and frozen during the second pass, so it can be read out of order
    rsc_u    = (state == S_ENC1) ? msg[0] : sys[ITL_PERM[step]];
  end

  rsc_encoder u_rsc (
    .clk   (clk_p_i),
    .rst   (reset_p_i),
    .clr   (rsc_clr),
    .en    (rsc_en),
    .term  (rsc_term),
    .u     (rsc_u),
    .sys_o (sys_bit),
    .par_o (par_bit)
  );

  always_ff @(posedge clk_p_i) begin
    if (reset_p_i) begin
      state       <= S_IDLE;
      in_ready_o  <= 1'b0;
      out_valid_o <= 1'b0;
      data_o      <= '0;
      step        <= '0;
      msg         <= '0;
      sys         <= '0;
      par1        <= '0;
      par2        <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          in_ready_o <= 1'b1;
          if (in_valid_i && in_ready_o) begin
            msg        <= data_i;
            step       <= '0;
            in_ready_o <= 1'b0;
            state      <= S_ENC1;
          end
        end
        S_ENC1: begin
          sys  <= {sys_bit, sys[EXTEND_SIZE-1:1]};
          par1 <= {par_bit, par1[EXTEND_SIZE-1:1]};
          msg  <= {1'b0, msg[INPUT_SIZE-1:1]};
          if (last) begin
            step  <= '0;
            state <= S_ENC2;
          end else begin
            step <= step + 3'd1;
          end
        end
        S_ENC2: begin
          par2 <= {par_bit, par2[EXTEND_SIZE-1:1]};
          if (last) begin
            step        <= '0;
            data_o      <= {sys, par1, par_bit, par2[EXTEND_SIZE-1:1]};
            out_valid_o <= 1'b1;
            state       <= S_OUT;
          end else begin
            step <= step + 3'd1;
          end
        end
        S_OUT: begin
          if (out_ready_i) begin
            out_valid_o <= 1'b0;
            in_ready_o  <= 1'b1;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_turbo_encoder.sv
// Bench for turbo_encoder: directed vectors with literal codewords plus a rule-level
// encoder model driving a per-cycle scoreboard on the output side.
module tb_turbo_encoder;
  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  data_in;
  logic        in_valid;
  logic        in_ready;
  logic [20:0] data_out;
  logic        out_valid;
  logic        out_ready;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;
  logic [20:0] exp_q[$];

  turbo_encoder dut (
    .clk_p_i     (clk),
    .reset_p_i   (reset),
    .data_i      (data_in),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .data_o      (data_out),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Codeword straight from the encoding rules: RSC 7/5 with tail, 3k mod 7 interleave.
  function automatic logic [20:0] enc(input logic [4:0] m);
    logic [6:0] s, p1, p2, il;
    logic s1, s2, u, a;
    s1 = 0; s2 = 0;
    for (int k = 0; k < 7; k++) begin
      u = (k < 5) ? m[k] : (s1 ^ s2);
      a = u ^ s1 ^ s2;
      s[k] = u; p1[k] = a ^ s2;
      s2 = s1; s1 = a;
    end
    for (int k = 0; k < 7; k++) il[k] = s[(3 * k) % 7];
    s1 = 0; s2 = 0;
    for (int k = 0; k < 7; k++) begin
      a = il[k] ^ s1 ^ s2;
      p2[k] = a ^ s2;
      s2 = s1; s1 = a;
    end
    return {s, p1, p2};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every cycle out_valid is high, data_out must equal the oldest accepted message's codeword.
  always @(negedge clk) begin
    if (reset) exp_q.delete();
    else begin
      if (out_valid) begin
        if (exp_q.size() == 0) chk("unexpected_valid", 32'(out_valid), 32'd0);
        else begin
          chk("scoreboard_data", 32'(data_out), 32'(exp_q[0]));
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      if (in_valid && in_ready) exp_q.push_back(enc(data_in));
    end
  end

  // Accept one message from idle, wait for the codeword, check latency and value, then drain it.
  task automatic run_block(input logic [4:0] m, input logic [20:0] exp, input string nm);
    int n;
    data_in = m; in_valid = 1; out_ready = 0;
    tick();
    in_valid = 0;
    n = 0;
    while (!out_valid && n < 40) begin tick(); n++; end
    chk({nm, "_latency"}, 32'(n), 32'd14);
    chk({nm, "_data"}, 32'(data_out), 32'(exp));
    out_ready = 1;
    tick();
    out_ready = 0;
    chk({nm, "_drained"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int n, last_acc, acc;
    logic [20:0] held;
    reset = 1; data_in = 0; in_valid = 0; out_ready = 0;
    tick(); tick();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(data_out), 32'd0);
    reset = 0;
    tick();
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    run_block(5'b00000, 21'h000000, "msg0");
    run_block(5'b00001, 21'h107BEB, "msg1");
    run_block(5'b00010, 21'h18A74C, "msg2");
    chk("idle_keeps_data", 32'(data_out), 32'h18A74C);

    // Back-pressure: output held, input side closed, in_valid pulses ignored.
    data_in = 5'b00001; in_valid = 1; out_ready = 0;
    tick();
    in_valid = 0;
    n = 0;
    while (!out_valid && n < 40) begin tick(); n++; end
    chk("hold_latency", 32'(n), 32'd14);
    held = data_out;
    chk("hold_value", 32'(held), 32'h107BEB);
    for (int i = 0; i < 10; i++) begin
      data_in = 5'(i + 7); in_valid = i[0];
      tick();
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_data", 32'(data_out), 32'(held));
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 0; out_ready = 1;
    tick();
    out_ready = 0;
    chk("hold_release_valid", 32'(out_valid), 32'd0);
    chk("hold_release_ready", 32'(in_ready), 32'd1);

    // Reset during the second pass aborts the block.
    data_in = 5'b11111; in_valid = 1;
    tick();
    in_valid = 0;
    for (int i = 0; i < 9; i++) tick();
    reset = 1;
    tick();
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_data", 32'(data_out), 32'd0);
    reset = 0;
    tick();
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out_valid) chk("abort_no_stale_valid", 32'(out_valid), 32'd0);
    end
    run_block(5'b00001, 21'h107BEB, "after_abort");

    // Back-to-back random traffic, output always ready.
    out_ready = 1; in_valid = 1; last_acc = -100;
    for (int b = 0; b < 100; b++) begin
      data_in = 5'($urandom);
      n = 0;
      while (!in_ready && n < 40) begin tick(); n++; end
      if (!in_ready) chk("rand_in_ready_timeout", 32'(in_ready), 32'd1);
      tick();
      acc = cyc;
      if (b > 0 && (acc - last_acc) < 15) chk("rand_spacing", 32'(acc - last_acc), 32'd15);
      last_acc = acc;
      n = 0;
      while (!out_valid && n < 40) begin tick(); n++; end
      chk("rand_latency", 32'(n), 32'd14);
      tick();
    end
    in_valid = 0;
    tick(); tick();
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
